// File: rtl/pia_multi.sv
// pia_multi: NPORTS-way 6821-style peripheral adapter with synchronised
// inputs, optional C1 input latch, selectable handshake trigger and OE pins.

module pia_multi_port #(
  parameter int WIDTH = 8,
  parameter bit LATCH = 1'b0,
  parameter bit WR_HS = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             acc_i,
  input  logic             rw_i,
  input  logic             a0_i,
  input  logic [7:0]       wdata_i,
  input  logic [WIDTH-1:0] pin_i,
  input  logic             c1_i,
  input  logic             c2_i,
  output logic [7:0]       rdata_o,
  output logic [WIDTH-1:0] pout_o,
  output logic [WIDTH-1:0] poe_o,
  output logic             c2_o,
  output logic             c2_oe_o,
  output logic             irq_o
);

  logic [WIDTH-1:0] ddr_q, ddr_d;
  logic [WIDTH-1:0] dat_q, dat_d;
  logic [WIDTH-1:0] lat_q, lat_d;
  logic [WIDTH-1:0] ps1_q, ps2_q;
  logic [5:0]       ctl_q, ctl_d;
  logic             f1_q, f1_d;
  logic             f2_q, f2_d;
  logic             c2o_q, c2o_d;
  logic             c1s1_q, c1s2_q, c1dl_q;
  logic             c2s1_q, c2s2_q, c2dl_q;

  logic             c1_edge, c2_edge;
  logic             dat_rd, dat_wr, ddr_wr, ctl_wr;
  logic             trig;
  logic [WIDTH-1:0] in_v, rd_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps1_q  <= '0;
      ps2_q  <= '0;
      c1s1_q <= 1'b0;
      c1s2_q <= 1'b0;
      c1dl_q <= 1'b0;
      c2s1_q <= 1'b0;
      c2s2_q <= 1'b0;
      c2dl_q <= 1'b0;
    end else begin
      ps1_q  <= pin_i;
      ps2_q  <= ps1_q;
      c1s1_q <= c1_i;
      c1s2_q <= c1s1_q;
      c1dl_q <= c1s2_q;
      c2s1_q <= c2_i;
      c2s2_q <= c2s1_q;
      c2dl_q <= c2s2_q;
    end
  end

  assign c1_edge = ctl_q[1] ? (c1s2_q & ~c1dl_q)
                            : (~c1s2_q & c1dl_q);
  assign c2_edge = ctl_q[4] ? (c2s2_q & ~c2dl_q)
                            : (~c2s2_q & c2dl_q);

  assign dat_rd = acc_i & rw_i & ~a0_i & ctl_q[2];
  assign dat_wr = acc_i & ~rw_i & ~a0_i & ctl_q[2];
  assign ddr_wr = acc_i & ~rw_i & ~a0_i & ~ctl_q[2];
  assign ctl_wr = acc_i & ~rw_i & a0_i;
  assign trig   = WR_HS ? dat_wr : dat_rd;

  always_comb begin
    ddr_d = ddr_q;
    dat_d = dat_q;
    ctl_d = ctl_q;
    lat_d = lat_q;
    f1_d  = f1_q;
    f2_d  = f2_q;
    c2o_d = c2o_q;
    if (ddr_wr) ddr_d = wdata_i[WIDTH-1:0];
    if (dat_wr) dat_d = wdata_i[WIDTH-1:0];
    if (ctl_wr) ctl_d = wdata_i[5:0];
    if (c1_edge) lat_d = ps2_q;
    if (c1_edge)     f1_d = 1'b1;
    else if (dat_rd) f1_d = 1'b0;
    // with C2 as an output, flag2 is frozen
    if (!ctl_q[5]) begin
      if (c2_edge)     f2_d = 1'b1;
      else if (dat_rd) f2_d = 1'b0;
    end
    unique case (1'b1)
      !ctl_q[5]: c2o_d = c2o_q;
      ctl_q[5] & ctl_q[4]: c2o_d = ctl_q[3];
      ctl_q[5] & ~ctl_q[4] & ~ctl_q[3]: begin
        if (trig)         c2o_d = 1'b0;
        else if (c1_edge) c2o_d = 1'b1;
      end
      ctl_q[5] & ~ctl_q[4] & ctl_q[3]: c2o_d = ~trig;
      default: c2o_d = c2o_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ddr_q <= '0;
      dat_q <= '0;
      lat_q <= '0;
      ctl_q <= '0;
      f1_q  <= 1'b0;
      f2_q  <= 1'b0;
      c2o_q <= 1'b0;
    end else begin
      ddr_q <= ddr_d;
      dat_q <= dat_d;
      lat_q <= lat_d;
      ctl_q <= ctl_d;
      f1_q  <= f1_d;
      f2_q  <= f2_d;
      c2o_q <= c2o_d;
    end
  end

  assign in_v = LATCH ? lat_q : ps2_q;
  assign rd_v = (ddr_q & dat_q) | (~ddr_q & in_v);

  always_comb begin
    rdata_o = '0;
    if (a0_i)          rdata_o = {f1_q, f2_q, ctl_q};
    else if (ctl_q[2]) rdata_o[WIDTH-1:0] = rd_v;
    else               rdata_o[WIDTH-1:0] = ddr_q;
  end

  assign pout_o  = dat_q;
  assign poe_o   = ddr_q;
  assign c2_o    = c2o_q;
  assign c2_oe_o = ctl_q[5];
  assign irq_o   = (f1_q & ctl_q[0])
                 | (f2_q & ctl_q[3] & ~ctl_q[5]);

endmodule

module pia_multi #(
  parameter int                NPORTS     = 2,
  parameter int                WIDTH      = 8,
  parameter logic [NPORTS-1:0] LATCH_EN   = '0,
  parameter logic [NPORTS-1:0] WR_HS_MASK = NPORTS'('b10)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cs,
  input  logic                      rw,
  input  logic [$clog2(NPORTS):0]   addr,
  input  logic [7:0]                data_in,
  output logic [7:0]                data_out,
  input  logic [NPORTS*WIDTH-1:0]   p_i,
  output logic [NPORTS*WIDTH-1:0]   p_o,
  output logic [NPORTS*WIDTH-1:0]   p_oe,
  input  logic [NPORTS-1:0]         c1,
  input  logic [NPORTS-1:0]         c2_i,
  output logic [NPORTS-1:0]         c2_o,
  output logic [NPORTS-1:0]         c2_oe,
  output logic [NPORTS-1:0]         irq,
  output logic                      irq_any
);

  localparam int AW = $clog2(NPORTS) + 1;
  localparam int PW = (AW > 1) ? AW - 1 : 1;

  logic [PW-1:0] psel;
  logic [7:0]    rd_arr [NPORTS];

  if (NPORTS > 1) begin : g_sel
    assign psel = addr[AW-1:1];
  end else begin : g_one
    assign psel = '0;
  end

  for (genvar g = 0; g < NPORTS; g++) begin : g_port
    pia_multi_port #(
      .WIDTH (WIDTH),
      .LATCH (LATCH_EN[g]),
      .WR_HS (WR_HS_MASK[g])
    ) u_port (
      .clk     (clk),
      .rst_n   (rst_n),
      .acc_i   (cs & (psel == PW'(g))),
      .rw_i    (rw),
      .a0_i    (addr[0]),
      .wdata_i (data_in),
      .pin_i   (p_i[g*WIDTH +: WIDTH]),
      .c1_i    (c1[g]),
      .c2_i    (c2_i[g]),
      .rdata_o (rd_arr[g]),
      .pout_o  (p_o[g*WIDTH +: WIDTH]),
      .poe_o   (p_oe[g*WIDTH +: WIDTH]),
      .c2_o    (c2_o[g]),
      .c2_oe_o (c2_oe[g]),
      .irq_o   (irq[g])
    );
  end

  // addresses past the last port read as zero
  assign data_out = (int'(psel) < NPORTS) ? rd_arr[psel] : 8'h00;
  assign irq_any  = |irq;

endmodule

// File: doc/pia_multi.md
# pia_multi

Parametrised multi-port peripheral interface adapter for the sound and CPU boards. It provides NPORTS independent ports, each WIDTH bits wide, with a 6821-style register model: DDR, data register, control register, two control lines (C1 and C2), interrupt flags, and C2 handshake/pulse output. Compared with the single-pair PIA it adds:

- fully synchronous single-edge design;
- input synchronisers;
- an optional C1-edge input latch;
- per-port selection of the handshake trigger (read or write);
- explicit output-enable pins in place of tristates.

## Interface

Parameters:
- NPORTS, 2: number of ports (1..8).
- WIDTH, 8: port width in bits (1..8); bus bits above WIDTH read 0 and are ignored on write.
- LATCH_EN, 0: NPORTS-bit mask; bit i set means port i data reads return the C1-latched input.
- WR_HS_MASK, 'b10: NPORTS-bit mask; bit i set means the handshake/pulse trigger is a data write (B-style); clear means a data read (A-style).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cs  in  1  chip select, one cycle per bus access.
- rw  in  1  1 = read, 0 = write.
- addr  in  clog2(NPORTS)+1  addr[0]: 0 = data/DDR, 1 = control; upper bits select port.
- data_in  in  8  write data.
- data_out  out  8  read data, combinational from addr and registers.
- p_i  in  NPORTS*WIDTH  port input pins, asynchronous.
- p_o  out  NPORTS*WIDTH  port output data (equals the data register).
- p_oe  out  NPORTS*WIDTH  output enable (equals the DDR).
- c1  in  NPORTS  C1 control inputs, asynchronous.
- c2_i  in  NPORTS  C2 inputs, asynchronous.
- c2_o  out  NPORTS  C2 output value.
- c2_oe  out  NPORTS  C2 output enable (equals ctrl[5]).
- irq  out  NPORTS  per-port interrupt.
- irq_any  out  1  OR of irq.

## Operation

**Control register per port** (ctrl[5:0] is R/W; bits 7:6 are read-only flags, and writes to them are ignored):
- bit0: C1 interrupt enable.
- bit1: C1 active edge (0 = fall, 1 = rise).
- bit2: addr[0]=0 selects the DDR (0) or data register (1).
- bits5:3: C2 mode.
- bit6: flag2.
- bit7: flag1.

**Input synchronisation.** p_i, c1 and c2_i each pass through a 2-flop synchroniser. C1 and C2 then go through a delay flop for edge detection.

**flag1.** Set on a C1 active edge. Cleared by a data-register read (cs & rw & addr[0]=0 & ctrl[2]=1). If set and clear coincide, set wins.

**flag2.** Same set/clear rules as flag1, using the C2 edge selected by ctrl[4]. It sets only while ctrl[5]=0. If ctrl[5]=1 it holds its value.

**irq[i]** = (flag1 & ctrl[0]) | (flag2 & ctrl[3] & ~ctrl[5]).

**C2 modes** (ctrl[5:3]):
- 0xx: C2 is an input. c2_o holds its last value.
- 100: handshake. c2_o is cleared by a trigger access and set by a C1 active edge. If both occur in the same cycle, clear wins.
- 101: pulse. c2_o is 0 for exactly the cycle after a trigger access and 1 otherwise.
- 110: c2_o = 0.
- 111: c2_o = 1.

**Trigger access** = a data-register access (ctrl[2]=1) of the type chosen by WR_HS_MASK[i]: a write if the bit is set, a read if clear.

**Data reads.** Each bit returns the data register bit if its DDR bit is 1; otherwise it returns the synchronised input. If LATCH_EN[i] is set, DDR=0 bits instead return a latch loaded from the synchronised input on each C1 active edge.

**Writes.** With addr[0]=0, a write goes to the DDR if ctrl[2]=0, else to the data register. With addr[0]=1, a write goes to ctrl[5:0].

**Reset.** Asynchronous, active-low, and may occur mid-access. It clears all DDR, data, control, flag, latch, synchroniser and c2_o registers. Immediately after reset:
- p_o, p_oe, c2_o, c2_oe, irq and irq_any are all 0;
- data_out is 0 for every addr.

## Timing

- **Register write:** takes effect at the rising edge ending the cs cycle; p_o/p_oe update at that edge.
- **Read data:** data_out is valid in the same cycle as addr; read side effects apply at the edge ending the cs cycle.
- **Input to edge detection:** an input edge before rising edge k is detected at edge k+2. The flag and latch update at k+2, so irq is high after k+2.
- **Data read of p_i:** reflects the pin 2 edges after it changes.
- **Handshake mode:** c2_o falls at the edge ending the trigger access. It rises at the C1 detection edge (k+2).
- **Pulse mode:** c2_o is low from the edge ending the access to the next edge (one clk period).
- **Back-to-back trigger accesses in pulse mode:** c2_o stays low continuously.

## Test plan

1. **Reset defaults.** Pulse rst_n low mid-write. Require all outputs 0, and data_out 0 at each of the 2*NPORTS addresses.
2. **DDR/data with mixed direction.** Port 0: write DDR=0x0F, ctrl=0x04, data=0xA5, with p_i=0x3C. Require p_o=0xA5, p_oe=0x0F, and a data read of 0x35.
3. **C1 interrupt.** Port 1: ctrl=0x07, then a c1 rising edge. Require flag1 and irq[1] high 2 edges after the synchronised edge, and control read = 0x87. A data read clears both. A coincident edge and read leaves flag1 = 1.
4. **Handshake, read-triggered (port 0).** Set ctrl=0x26 and raise c1. Require c2_o=1. A data read drops c2_o; the next c1 rise restores it.
5. **Pulse mode, write-triggered (port 1).** Set ctrl=0x2C and write data 0x55. Require c2_o=0 for exactly one cycle, then 1.
6. **Input latch.** LATCH_EN=1 on port 0. Apply p_i=0x12, then a c1 fall (ctrl=0x04), then p_i=0x34. Require a data read of 0x12.
